nyq_tap_sequencer: RTL

- Upstream control/data stage for the Nyquist filter MAC (single signed accumulator: clear loads 0, enable adds a*b).
- Holds a NUM_TAPS-deep circular sample delay line and a programmable coefficient register file.
- For each accepted input sample, it sequences one clear cycle and then NUM_TAPS multiply-accumulate cycles into the MAC.
- It then captures the MAC result and presents it on a valid/ready output.

---
 rtl/nyq_tap_sequencer.sv | 94 +++++++++
 1 files changed

// File: rtl/nyq_tap_sequencer.sv
// nyq_tap_sequencer: circular delay line + coefficient file that drives one clear and NUM_TAPS MAC cycles per sample.
module nyq_tap_sequencer #(
  parameter int DATA_WIDTH = 10,
  parameter int COEF_WIDTH = 10,
  parameter int NUM_TAPS   = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                        Clk_CI,
  input  logic                        Rst_RI,
  input  logic                        InValid_SI,
  input  logic [DATA_WIDTH-1:0]       InData_DI,
  output logic                        InReady_SO,
  input  logic                        CoefWrEn_SI,
  input  logic [$clog2(NUM_TAPS)-1:0] CoefAddr_DI,
  input  logic [COEF_WIDTH-1:0]       CoefData_DI,
  output logic                        MacClr_SO,
  output logic                        MacWrEn_SO,
  output logic [DATA_WIDTH-1:0]       MacIn0_DO,
  output logic [COEF_WIDTH-1:0]       MacIn1_DO,
  input  logic [ACC_WIDTH-1:0]        MacOut_DI,
  output logic                        OutValid_SO,
  output logic [ACC_WIDTH-1:0]        OutData_DO,
  input  logic                        OutReady_SI
);
  localparam int AW = $clog2(NUM_TAPS);
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, CAPTURE, HOLD} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, newest_q, newest_d, k_q, k_d, rd_idx;
  logic [DATA_WIDTH-1:0] dly_q [NUM_TAPS];
  logic [COEF_WIDTH-1:0] coef_q [NUM_TAPS];
  logic [ACC_WIDTH-1:0] out_q;
  logic accept, coef_we;
  assign accept = state_q == IDLE && InValid_SI;
  assign coef_we = state_q == IDLE && CoefWrEn_SI && int'(CoefAddr_DI) < NUM_TAPS;
  // Tap k reads the sample k steps older than the newest one, wrapping modulo NUM_TAPS.
  assign rd_idx = newest_q >= k_q ? newest_q - k_q : AW'(NUM_TAPS) + newest_q - k_q;
  assign OutData_DO = out_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    wptr_d = wptr_q;
    newest_d = newest_q;
    InReady_SO = state_q == IDLE;
    MacClr_SO = state_q == CLEAR;
    MacWrEn_SO = state_q == CLEAR || state_q == ACCUM;
    MacIn0_DO = state_q == ACCUM ? dly_q[rd_idx] : '0;
    MacIn1_DO = state_q == ACCUM ? coef_q[k_q] : '0;
    OutValid_SO = state_q == HOLD;
    case (state_q)
      IDLE: if (InValid_SI) begin
        state_d = CLEAR;
        newest_d = wptr_q;
        wptr_d = wptr_q == AW'(NUM_TAPS - 1) ? '0 : wptr_q + AW'(1);
      end
      CLEAR: begin
        state_d = ACCUM;
        k_d = '0;
      end
      ACCUM: begin
        k_d = k_q + AW'(1);
        state_d = k_q == AW'(NUM_TAPS - 1) ? CAPTURE : ACCUM;
      end
      CAPTURE: state_d = HOLD;
      HOLD: state_d = OutReady_SI ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q <= IDLE;
      wptr_q <= '0;
      newest_q <= '0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      newest_q <= newest_d;
      k_q <= k_d;
    end
  end
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      out_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        dly_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (accept) dly_q[wptr_q] <= InData_DI;
      if (coef_we) coef_q[CoefAddr_DI] <= CoefData_DI;
      if (state_q == CAPTURE) out_q <= MacOut_DI;
    end
  end
endmodule
